// File: rtl/mldsa_params_pkg.sv
// ML-DSA arithmetic parameters shared by the sampling datapaths.
package mldsa_params_pkg;

  localparam int MLDSA_Q       = 8380417;
  localparam int MLDSA_Q_WIDTH = 23;
  localparam int MLDSA_N       = 256;

endpackage

// File: rtl/mldsa_sampler_pkg.sv
// ExpandMask sampler constants and controller state encoding.
package mldsa_sampler_pkg;
  import mldsa_params_pkg::*;

  localparam int EXP_PISO_INPUT_RATE  = 1088;
  localparam int EXP_NUM_SAMPLERS     = 4;
  localparam int EXP_SAMPLE_W         = 20;
  localparam int EXP_PISO_OUTPUT_RATE = EXP_NUM_SAMPLERS * EXP_SAMPLE_W;
  localparam int EXP_PISO_BUFFER_W    = EXP_PISO_INPUT_RATE + EXP_PISO_OUTPUT_RATE;
  localparam int EXP_VLD_SAMPLES      = 4;
  localparam int EXP_VLD_SAMPLE_W     = MLDSA_Q_WIDTH;

  localparam int EXP_GAMMA1           = 1 << 19;
  localparam int EXP_NUM_BEATS        = MLDSA_N / EXP_VLD_SAMPLES;

  typedef enum logic [1:0] {
    EXP_IDLE = 2'd0,
    EXP_RUN  = 2'd1,
    EXP_DONE = 2'd2
  } exp_state_e;

endpackage

// File: rtl/abr_piso.sv
// Generic LSB-first parallel-in/serial-out buffer: appends wide blocks, drains fixed-width groups.
// Optional checks compiled in with EXP_MASK_ASSERT_EN.
module abr_piso #(
  parameter int INPUT_RATE  = 1088,
  parameter int OUTPUT_RATE = 80,
  parameter int BUFFER_W    = 1168
) (
  input  logic                   clk,
  input  logic                   rst_b,
  input  logic                   zeroize,
  input  logic                   wr_valid,
  output logic                   wr_hold,
  input  logic [INPUT_RATE-1:0]  wr_data,
  output logic                   rd_valid,
  input  logic                   rd_req,
  output logic [OUTPUT_RATE-1:0] rd_data
);

  localparam int CNT_W = $clog2(BUFFER_W + 1);
  localparam logic [CNT_W-1:0] IN_C   = CNT_W'(INPUT_RATE);
  localparam logic [CNT_W-1:0] OUT_C  = CNT_W'(OUTPUT_RATE);
  localparam logic [CNT_W-1:0] HOLD_C = CNT_W'(BUFFER_W - INPUT_RATE);

  logic [BUFFER_W-1:0] buffer;
  logic [BUFFER_W-1:0] buf_shift;
  logic [BUFFER_W-1:0] buf_next;
  logic [CNT_W-1:0]    count;
  logic [CNT_W-1:0]    cnt_shift;
  logic [CNT_W-1:0]    cnt_next;
  logic                wr_en;
  logic                rd_en;

  assign rd_valid = (count >= OUT_C);
  assign wr_hold  = (count > HOLD_C);
  assign rd_data  = buffer[OUTPUT_RATE-1:0];
  assign wr_en    = wr_valid && !wr_hold;
  assign rd_en    = rd_req && rd_valid;

  // Drain happens first so the appended block lands right after the surviving bits.
  always_comb begin
    buf_shift = buffer;
    cnt_shift = count;
    if (rd_en) begin
      buf_shift = buffer >> OUTPUT_RATE;
      cnt_shift = count - OUT_C;
    end
    buf_next = buf_shift;
    cnt_next = cnt_shift;
    if (wr_en) begin
      buf_next = buf_shift | (BUFFER_W'(wr_data) << cnt_shift);
      cnt_next = cnt_shift + IN_C;
    end
  end

  // Bits above count must stay zero, so contents are cleared along with count.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      buffer <= '0;
      count  <= '0;
    end else if (zeroize) begin
      buffer <= '0;
      count  <= '0;
    end else begin
      buffer <= buf_next;
      count  <= cnt_next;
    end
  end

`ifdef EXP_MASK_ASSERT_EN
  count_in_range: assert property (@(posedge clk) disable iff (!rst_b)
    count <= CNT_W'(BUFFER_W));

  no_append_on_hold: assert property (@(posedge clk) disable iff (!rst_b)
    (wr_hold && !zeroize) |=> (count <= $past(count)));
`endif

endmodule

// File: rtl/exp_mask_top.sv
// ML-DSA ExpandMask datapath: PISO of SHAKE256 blocks, 20-bit sample to mask coefficient mod q.
// Optional SVA checks compiled in with EXP_MASK_ASSERT_EN.
module exp_mask_top
  import mldsa_params_pkg::*;
#(
  parameter int EXP_PISO_INPUT_RATE  = mldsa_sampler_pkg::EXP_PISO_INPUT_RATE,
  parameter int EXP_PISO_OUTPUT_RATE = mldsa_sampler_pkg::EXP_PISO_OUTPUT_RATE,
  parameter int EXP_PISO_BUFFER_W    = mldsa_sampler_pkg::EXP_PISO_BUFFER_W,
  parameter int EXP_NUM_SAMPLERS     = mldsa_sampler_pkg::EXP_NUM_SAMPLERS,
  parameter int EXP_SAMPLE_W         = mldsa_sampler_pkg::EXP_SAMPLE_W,
  parameter int EXP_VLD_SAMPLES      = mldsa_sampler_pkg::EXP_VLD_SAMPLES,
  parameter int EXP_VLD_SAMPLE_W     = mldsa_sampler_pkg::EXP_VLD_SAMPLE_W
) (
  input  logic                                             clk,
  input  logic                                             rst_b,
  input  logic                                             zeroize,
  input  logic                                             data_valid_i,
  output logic                                             data_hold_o,
  input  logic [EXP_PISO_INPUT_RATE-1:0]                   data_i,
  output logic                                             data_valid_o,
  output logic [EXP_VLD_SAMPLES-1:0][EXP_VLD_SAMPLE_W-1:0] data_o
);

  localparam int MAP_W = EXP_VLD_SAMPLE_W + 2;
  localparam logic signed [MAP_W-1:0] GAMMA1_S = MAP_W'(mldsa_sampler_pkg::EXP_GAMMA1);
  localparam logic signed [MAP_W-1:0] Q_S      = MAP_W'(MLDSA_Q);
  localparam logic [5:0] LAST_BEAT = 6'(mldsa_sampler_pkg::EXP_NUM_BEATS - 1);

  mldsa_sampler_pkg::exp_state_e state;

  logic                                             done;
  logic                                             wr_valid;
  logic                                             piso_hold;
  logic                                             piso_rd;
  logic                                             vld_p0;
  logic [EXP_PISO_OUTPUT_RATE-1:0]                  samples_p0;
  logic [EXP_VLD_SAMPLES-1:0][EXP_VLD_SAMPLE_W-1:0] coeff_p0;
  logic [EXP_VLD_SAMPLES-1:0][EXP_VLD_SAMPLE_W-1:0] coeff_p1;
  logic                                             vld_p1;
  logic [5:0]                                       beat_cnt;

  // gamma1 - r, folded into [0, q) when the sample exceeds gamma1.
  function automatic logic [EXP_VLD_SAMPLE_W-1:0] map_sample(input logic [EXP_SAMPLE_W-1:0] r);
    logic signed [MAP_W-1:0] diff;
    diff = GAMMA1_S - $signed(MAP_W'(r));
    if (diff < 0)
      diff = diff + Q_S;
    return diff[EXP_VLD_SAMPLE_W-1:0];
  endfunction

  assign done        = (state == mldsa_sampler_pkg::EXP_DONE);
  assign wr_valid    = data_valid_i && !done;
  assign piso_rd     = vld_p0 && !done;
  assign data_hold_o = piso_hold | done;

  abr_piso #(
    .INPUT_RATE  (EXP_PISO_INPUT_RATE),
    .OUTPUT_RATE (EXP_PISO_OUTPUT_RATE),
    .BUFFER_W    (EXP_PISO_BUFFER_W)
  ) u_piso (
    .clk      (clk),
    .rst_b    (rst_b),
    .zeroize  (zeroize),
    .wr_valid (wr_valid),
    .wr_hold  (piso_hold),
    .wr_data  (data_i),
    .rd_valid (vld_p0),
    .rd_req   (piso_rd),
    .rd_data  (samples_p0)
  );

  // p0: combinational mapping of the PISO head group
  always_comb begin
    coeff_p0 = '0;
    for (int i = 0; i < EXP_NUM_SAMPLERS; i++)
      coeff_p0[i] = map_sample(samples_p0[i*EXP_SAMPLE_W +: EXP_SAMPLE_W]);
  end

  // p1: registered beat and polynomial controller
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state    <= mldsa_sampler_pkg::EXP_IDLE;
      beat_cnt <= '0;
      vld_p1   <= 1'b0;
      coeff_p1 <= '0;
    end else if (zeroize) begin
      state    <= mldsa_sampler_pkg::EXP_IDLE;
      beat_cnt <= '0;
      vld_p1   <= 1'b0;
      coeff_p1 <= '0;
    end else begin
      vld_p1 <= piso_rd;
      if (piso_rd) begin
        coeff_p1 <= coeff_p0;
        beat_cnt <= beat_cnt + 6'd1;
        if (beat_cnt == LAST_BEAT)
          state <= mldsa_sampler_pkg::EXP_DONE;
        else
          state <= mldsa_sampler_pkg::EXP_RUN;
      end
    end
  end

  assign data_valid_o = vld_p1;
  assign data_o       = coeff_p1;

`ifdef EXP_MASK_ASSERT_EN
  logic [7:0] beats_seen;

  function automatic logic lanes_below_q(
    input logic [EXP_VLD_SAMPLES-1:0][EXP_VLD_SAMPLE_W-1:0] c);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < EXP_VLD_SAMPLES; i++)
      if (c[i] >= EXP_VLD_SAMPLE_W'(MLDSA_Q))
        ok = 1'b0;
    return ok;
  endfunction

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b)
      beats_seen <= '0;
    else if (zeroize)
      beats_seen <= '0;
    else if (vld_p1)
      beats_seen <= beats_seen + 8'd1;
  end

  no_transfer_on_hold: assert property (@(posedge clk) disable iff (!rst_b)
    data_hold_o |-> !(wr_valid && !piso_hold));

  coeff_below_q: assert property (@(posedge clk) disable iff (!rst_b)
    vld_p1 |-> lanes_below_q(coeff_p1));

  beats_bounded: assert property (@(posedge clk) disable iff (!rst_b)
    beats_seen <= 8'd64);
`endif

endmodule

// File: tb/tb_exp_mask_top.sv
// Directed/random bench for exp_mask_top against a bit-stream reference of the ExpandMask mapping.
module tb_exp_mask_top;

  logic              clk = 1'b0;
  logic              rst_b;
  logic              zeroize;
  logic              data_valid_i;
  logic              data_hold_o;
  logic [1087:0]     data_i;
  logic              data_valid_o;
  logic [3:0][22:0]  data_o;

  int vectors     = 0;
  int miscompares = 0;

  logic [1087:0]     blocks [8];
  logic [8*1088-1:0] stream;
  int                blk_idx;
  int                m_cnt;
  int                m_beats;
  bit                m_done;
  int                dut_beats;
  int                cyc;
  int                first_xfer_cyc;
  int                first_vld_cyc;
  logic [91:0]       first_beat;

  exp_mask_top dut (
    .clk          (clk),
    .rst_b        (rst_b),
    .zeroize      (zeroize),
    .data_valid_i (data_valid_i),
    .data_hold_o  (data_hold_o),
    .data_i       (data_i),
    .data_valid_o (data_valid_o),
    .data_o       (data_o)
  );

  always #5 clk = ~clk;

  function automatic int ref_coeff(input int r);
    if (r <= 524288)
      return 524288 - r;
    else
      return 524288 - r + 8380417;
  endfunction

  function automatic logic [91:0] ref_beat(input int k);
    logic [91:0] b;
    logic [19:0] r;
    b = '0;
    for (int i = 0; i < 4; i++) begin
      r = stream[20*(4*k+i) +: 20];
      b[23*i +: 23] = 23'(ref_coeff(int'(r)));
    end
    return b;
  endfunction

  task automatic chk(input string tag, input logic [91:0] got, input logic [91:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic build_stream();
    for (int b = 0; b < 8; b++)
      stream[1088*b +: 1088] = blocks[b];
  endtask

  task automatic new_poly();
    for (int b = 0; b < 8; b++)
      for (int w = 0; w < 34; w++)
        blocks[b][32*w +: 32] = $urandom();
    build_stream();
    first_xfer_cyc = -1;
    first_vld_cyc  = -1;
    first_beat     = '0;
  endtask

  task automatic model_clear();
    m_cnt     = 0;
    m_beats   = 0;
    m_done    = 1'b0;
    blk_idx   = 0;
    dut_beats = 0;
  endtask

  // One clock: drive inputs, advance the reference, compare after the edge.
  task automatic cycle(input bit dv, input bit zz);
    bit xfer;
    bit consume;
    int pre_beats;
    data_valid_i = dv;
    zeroize      = zz;
    data_i       = blocks[(blk_idx > 7) ? 7 : blk_idx];
    xfer      = dv && !zz && !(m_cnt > 80 || m_done);
    consume   = !zz && (m_cnt >= 80) && !m_done;
    pre_beats = m_beats;
    @(posedge clk);
    #1;
    cyc++;
    if (zz) begin
      model_clear();
      chk("zeroize_valid", 92'(data_valid_o), 92'(0));
      chk("zeroize_data", data_o, 92'(0));
      chk("zeroize_hold", 92'(data_hold_o), 92'(0));
    end else begin
      if (consume) begin
        m_cnt = m_cnt - 80;
        m_beats++;
        if (m_beats == 64) m_done = 1'b1;
      end
      if (xfer) begin
        m_cnt = m_cnt + 1088;
        blk_idx++;
        if (first_xfer_cyc < 0) first_xfer_cyc = cyc;
      end
      chk("valid", 92'(data_valid_o), 92'(consume));
      if (data_valid_o) begin
        dut_beats++;
        if (first_vld_cyc < 0) first_vld_cyc = cyc;
      end
      if (consume) begin
        chk($sformatf("beat%0d", pre_beats), data_o, ref_beat(pre_beats));
        if (pre_beats == 0) first_beat = data_o;
      end
      chk("hold", 92'(data_hold_o), 92'((m_cnt > 80) || m_done));
    end
  endtask

  task automatic run_to(input int target, input bit gaps);
    int budget;
    budget = 3000;
    while (m_beats < target && budget > 0) begin
      cycle(gaps ? ($urandom_range(0, 3) != 0) : 1'b1, 1'b0);
      budget--;
    end
    chk($sformatf("beats_seen_%0d", target), 92'(dut_beats), 92'(target));
  endtask

  task automatic idle_done(input int n);
    for (int i = 0; i < n; i++)
      cycle(1'b1, 1'b0);
  endtask

  initial begin
    rst_b        = 1'b0;
    zeroize      = 1'b0;
    data_valid_i = 1'b0;
    data_i       = '0;
    cyc          = 0;
    model_clear();
    new_poly();

    repeat (2) @(posedge clk);
    #1;
    chk("reset_valid", 92'(data_valid_o), 92'(0));
    chk("reset_data", data_o, 92'(0));
    chk("reset_hold", 92'(data_hold_o), 92'(0));
    rst_b = 1'b1;

    // all-zero first block, full polynomial, then hold after beat 64
    new_poly();
    blocks[0] = '0;
    build_stream();
    run_to(64, 1'b0);
    chk("zero_first_beat", first_beat, {4{23'h080000}});
    chk("first_latency", 92'(first_vld_cyc - first_xfer_cyc), 92'(1));
    idle_done(8);
    cycle(1'b1, 1'b1);

    // mapping boundary samples in lanes 0..3
    new_poly();
    blocks[0][79:0] = {20'h00001, 20'hFFFFF, 20'h80001, 20'h80000};
    build_stream();
    run_to(64, 1'b0);
    chk("lane_map", first_beat, {23'h07FFFF, 23'h77E002, 23'h7FE000, 23'h000000});
    idle_done(4);
    cycle(1'b0, 1'b1);

    // gapped input, zeroize at beat 20, then a clean polynomial
    new_poly();
    run_to(20, 1'b1);
    cycle(1'b1, 1'b1);
    new_poly();
    run_to(64, 1'b1);
    idle_done(4);
    cycle(1'b0, 1'b1);

    // asynchronous reset at beat 30
    new_poly();
    run_to(30, 1'b0);
    data_valid_i = 1'b0;
    #3;
    rst_b = 1'b0;
    #1;
    chk("async_rst_valid", 92'(data_valid_o), 92'(0));
    chk("async_rst_data", data_o, 92'(0));
    chk("async_rst_hold", 92'(data_hold_o), 92'(0));
    model_clear();
    @(posedge clk);
    #1;
    rst_b = 1'b1;
    new_poly();
    run_to(64, 1'b0);
    idle_done(4);

    // one more random polynomial with gaps
    cycle(1'b0, 1'b1);
    new_poly();
    run_to(64, 1'b1);
    idle_done(4);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
